// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types and constants for the RAM built-in self test
// Purpose: FSM state encoding, test pattern base constant and error counter width.
// Ports: none (package).
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Alternating 1010... constant, MSB set; word-wide slices are taken from the top.
  localparam logic [63:0] PAT_BASE = {32{2'b10}};

  localparam int ERR_W = 16;

endpackage

// File: rtl/ram_bist_pattern.sv
// rtl/ram_bist_pattern.sv - test pattern generator PAT(a) / ~PAT(a)
// Purpose: word = resize(addr) ^ alternating constant, optionally inverted.
// Ports:
//   addr   in   ADDR_W     word address
//   invert in   1          select ~PAT(addr)
//   word   out  BIT_DEPTH  pattern word
module ram_bist_pattern
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int BIT_DEPTH = 8
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 invert,
  output logic [BIT_DEPTH-1:0] word
);

  // Top BIT_DEPTH bits of the base so the slice always starts with a 1.
  localparam logic [BIT_DEPTH-1:0] ALT = PAT_BASE[63 -: BIT_DEPTH];

  logic [BIT_DEPTH-1:0] addr_ext;

  generate
    if (BIT_DEPTH > ADDR_W) begin : g_ext
      assign addr_ext = {{(BIT_DEPTH - ADDR_W){1'b0}}, addr};
    end else begin : g_trunc
      assign addr_ext = addr[BIT_DEPTH-1:0];
    end
  endgenerate

  assign word = invert ? ~(addr_ext ^ ALT) : (addr_ext ^ ALT);

endmodule

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - march-style write/read-compare self test for a single-port RAM
// Purpose: writes PAT(a) to every word, reads back and compares with a one-stage
//   pipeline, reports pass/first failing address/saturating error count.
// Optional macro RAM_BIST_INVERT_PASS_EN: adds a second pass using ~PAT(a).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin test (honoured only in IDLE/DONE)
//   busy, done     test running / test complete (held until next start)
//   pass           no mismatches (valid while done)
//   fail_addr      first mismatching address
//   err_count      saturating mismatch count
//   mem_addr, mem_wen, mem_data_in   RAM request
//   mem_data_out   RAM read data, one cycle after the address
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int BIT_SIZE  = 1024,
  parameter int BIT_DEPTH = 8,
  localparam int DEPTH    = BIT_SIZE / BIT_DEPTH,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_wen,
  output logic [BIT_DEPTH-1:0] mem_data_in,
  input  logic [BIT_DEPTH-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [BIT_DEPTH-1:0] pat_word;
  logic [BIT_DEPTH-1:0] exp_q;
  logic [ADDR_W-1:0]    exp_addr_q;
  logic                 cmp_valid_q;
  logic                 invert;
  logic                 accept;
  logic                 last_addr;
  logic                 mismatch;

`ifdef RAM_BIST_INVERT_PASS_EN
  logic second_q;
  assign invert = second_q;
`else
  assign invert = 1'b0;
`endif

  assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_addr = (addr_q == LAST);
  assign mismatch  = cmp_valid_q && (mem_data_out != exp_q);

  // One generator serves both the write data and the expected read data.
  ram_bist_pattern #(
    .ADDR_W   (ADDR_W),
    .BIT_DEPTH(BIT_DEPTH)
  ) u_pattern (
    .addr  (addr_q),
    .invert(invert),
    .word  (pat_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_WRITE;
      ST_WRITE:         if (last_addr) state_d = ST_READ;
      ST_READ:          if (last_addr) state_d = ST_DRAIN;
`ifdef RAM_BIST_INVERT_PASS_EN
      ST_DRAIN:         state_d = second_q ? ST_DONE : ST_WRITE;
`else
      ST_DRAIN:         state_d = ST_DONE;
`endif
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      exp_q       <= '0;
      exp_addr_q  <= '0;
      cmp_valid_q <= 1'b0;
      fail_addr   <= '0;
      err_count   <= '0;
`ifdef RAM_BIST_INVERT_PASS_EN
      second_q    <= 1'b0;
`endif
    end else begin
      // Read address a is compared one cycle later, when the RAM data arrives.
      cmp_valid_q <= (state_q == ST_READ);
      if (state_q == ST_READ) begin
        exp_q      <= pat_word;
        exp_addr_q <= addr_q;
      end
      if (state_q == ST_WRITE || state_q == ST_READ) begin
        addr_q <= last_addr ? '0 : addr_q + 1'b1;
      end
`ifdef RAM_BIST_INVERT_PASS_EN
      if (state_q == ST_DRAIN) second_q <= 1'b1;
`endif
      if (accept) begin
        addr_q    <= '0;
        fail_addr <= '0;
        err_count <= '0;
`ifdef RAM_BIST_INVERT_PASS_EN
        second_q  <= 1'b0;
`endif
      end else if (mismatch) begin
        // Counter saturates, so zero reliably marks the first mismatch.
        if (err_count == '0) fail_addr <= exp_addr_q;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  assign busy        = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (err_count == '0);
  assign mem_wen     = (state_q == ST_WRITE);
  assign mem_addr    = (state_q == ST_WRITE || state_q == ST_READ) ? addr_q : '0;
  assign mem_data_in = (state_q == ST_WRITE) ? pat_word : '0;

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - directed bench for ram_bist with a behavioural RAM and fault modes
module tb_ram_bist;

`ifdef RAM_BIST_INVERT_PASS_EN
  localparam int DONE_EDGE = 515;
  localparam int IGN_ERR   = 4;
`else
  localparam int DONE_EDGE = 258;
  localparam int IGN_ERR   = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [6:0] fail_addr;
  logic [15:0] err_count;
  logic [6:0] mem_addr;
  logic       mem_wen;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;

  int total = 0;
  int bad = 0;
  int fault_mode = 0;

  always #5 clk = ~clk;

  ram_bist #(.BIT_SIZE(1024), .BIT_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_addr   (fail_addr),
    .err_count   (err_count),
    .mem_addr    (mem_addr),
    .mem_wen     (mem_wen),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Behavioural synchronous RAM; faults applied on the read path.
  logic [7:0] ram [128];
  logic [7:0] rd_q = 8'h00;
  logic [6:0] rd_addr_q = 7'd0;

  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_data_in;
    rd_q      <= ram[mem_addr];
    rd_addr_q <= mem_addr;
  end

  assign mem_data_out =
      (fault_mode == 2 && (rd_addr_q == 7'd3 || rd_addr_q == 7'd100)) ? 8'h00 :
      (fault_mode == 1 && rd_addr_q == 7'd5) ? (rd_q & 8'h7F) : rd_q;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " mem_wen"}, 32'(mem_wen), 32'd0);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, " mem_data_in"}, 32'(mem_data_in), 32'd0);
  endtask

  // Returns the number of rising edges, counting the start-sampling edge as 1,
  // until done is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_one(input int mode, input logic exp_pass, input int exp_fail,
                         input int exp_err, input string tag);
    int n;
    fault_mode = mode;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, " done edge"}, 32'(n), 32'(DONE_EDGE));
    check({tag, " pass"}, 32'(pass), 32'(exp_pass));
    check({tag, " fail_addr"}, 32'(fail_addr), 32'(exp_fail));
    check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
    check_idle_outputs(tag);
  endtask

  typedef struct {
    int   mode;
    logic exp_pass;
    int   exp_fail;
    int   exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int trace_err;
    logic [7:0] exp_d;

    vecs[0] = '{mode: 0, exp_pass: 1'b1, exp_fail: 0, exp_err: 0};
    vecs[1] = '{mode: 1, exp_pass: 1'b0, exp_fail: 5, exp_err: 1};
    vecs[2] = '{mode: 2, exp_pass: 1'b0, exp_fail: 3, exp_err: IGN_ERR};
    vecs[3] = '{mode: 0, exp_pass: 1'b1, exp_fail: 0, exp_err: 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset done", 32'(done), 32'd0);
    check("reset pass", 32'(pass), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_one(vecs[i].mode, vecs[i].exp_pass, vecs[i].exp_fail, vecs[i].exp_err,
              $sformatf("vec%0d", i));
    end

    // Write-phase trace.
    fault_mode = 0;
    trace_err = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int a = 0; a < 128; a++) begin
      exp_d = 8'(a) ^ 8'hAA;
      if (mem_wen !== 1'b1 || mem_addr !== 7'(a) || mem_data_in !== exp_d) trace_err++;
      if (a == 127) check("trace data 0x7f", 32'(mem_data_in), 32'hD5);
      @(posedge clk); #1;
    end
    check("trace write errors", 32'(trace_err), 32'd0);
    check("trace wen on read", 32'(mem_wen), 32'd0);
    check("trace busy on read", 32'(busy), 32'd1);
    wait_done(n);
    check("trace pass", 32'(pass), 32'd1);

    // Asynchronous reset in cycle 60 of WRITE, after an errored test.
    run_one(1, 1'b0, 5, 1, "pre-reset");
    fault_mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    check("midtest mem_addr", 32'(mem_addr), 32'd59);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("async done", 32'(done), 32'd0);
    check("async pass", 32'(pass), 32'd0);
    check("async fail_addr", 32'(fail_addr), 32'd0);
    check("async err_count", 32'(err_count), 32'd0);
    check_idle_outputs("async");
    @(negedge clk); rst_n = 1'b1;
    run_one(0, 1'b1, 0, 0, "after reset");

    // Start held high across a whole test.
    fault_mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    check("held done edge", 32'(n), 32'(DONE_EDGE));
    check("held pass", 32'(pass), 32'd1);
    @(posedge clk); #1;
    check("held restart done", 32'(done), 32'd0);
    check("held restart busy", 32'(busy), 32'd1);
    check("held restart wen", 32'(mem_wen), 32'd1);
    check("held restart addr", 32'(mem_addr), 32'd0);
    @(negedge clk); start = 1'b0;
    wait_done(n);
    check("held second done", 32'(done), 32'd1);
    check("held second pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
